// File: rtl/reg_file_if.sv
// Register file bus: decode read ports, write-back write port, and status.
interface reg_file_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  read_en_1;
  logic [ADDR_WIDTH-1:0] read_addr_1;
  logic [DATA_WIDTH-1:0] read_data_1;
  logic                  read_en_2;
  logic [ADDR_WIDTH-1:0] read_addr_2;
  logic [DATA_WIDTH-1:0] read_data_2;
  logic                  write_en;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  busy;
  logic                  write_dropped;

  modport master (
    output read_en_1, read_addr_1, read_en_2, read_addr_2,
           write_en, write_addr, write_data,
    input  read_data_1, read_data_2, busy, write_dropped
  );

  modport slave (
    input  read_en_1, read_addr_1, read_en_2, read_addr_2,
           write_en, write_addr, write_data,
    output read_data_1, read_data_2, busy, write_dropped
  );
endinterface

// File: rtl/reg_file.sv
// General-purpose register file: 2 combinational read ports with write
// bypass, 1 write port, r0 hardwired to zero, and a post-reset clear
// sequencer that zeroes the array one entry per cycle.

// One read port: gating, bypass and storage select.
module reg_file_rd_port #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  busy,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] stored,
  output logic [DATA_WIDTH-1:0] data
);
  // Priority: forced zero, then same-cycle write bypass, then storage.
  always_comb begin
    data = stored;
    if (!en || addr == '0 || busy) data = '0;
    else if (we && waddr == addr)  data = wdata;
  end
endmodule

module reg_file #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_if.slave    bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;
  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_idx;
  logic                  write_dropped;

  // Entry 0 is never written and never selected (r0 reads are forced to
  // zero), so it trims away; the array carries no reset so it can map to RAM.
  logic [DATA_WIDTH-1:0] regs [DEPTH];

  logic wr_valid;
  assign wr_valid = bus.write_en && (bus.write_addr != '0);

  // Clear sequencer and sticky dropped-write flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= CLEAR;
      clr_idx       <= FIRST_IDX;
      write_dropped <= 1'b0;
    end else if (state == CLEAR) begin
      clr_idx <= clr_idx + 1'b1;
      if (clr_idx == LAST_IDX) state <= IDLE;
      if (wr_valid) write_dropped <= 1'b1;
    end
  end

  // Array write: clear entry while sequencing, otherwise the write-back port.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == CLEAR) regs[clr_idx] <= '0;
      else if (wr_valid)  regs[bus.write_addr] <= bus.write_data;
    end
  end

  assign bus.busy          = (state == CLEAR);
  assign bus.write_dropped = write_dropped;

  logic [1:0]                 rd_en;
  logic [1:0][ADDR_WIDTH-1:0] rd_addr;
  logic [1:0][DATA_WIDTH-1:0] rd_data;
  logic [1:0][DATA_WIDTH-1:0] rd_stored;

  assign rd_en   = {bus.read_en_2, bus.read_en_1};
  assign rd_addr = {bus.read_addr_2, bus.read_addr_1};

  for (genvar p = 0; p < 2; p++) begin : g_rd
    assign rd_stored[p] = regs[rd_addr[p]];
    reg_file_rd_port #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_port (
      .en     (rd_en[p]),
      .addr   (rd_addr[p]),
      .busy   (bus.busy),
      .we     (bus.write_en),
      .waddr  (bus.write_addr),
      .wdata  (bus.write_data),
      .stored (rd_stored[p]),
      .data   (rd_data[p])
    );
  end

  assign bus.read_data_1 = rd_data[0];
  assign bus.read_data_2 = rd_data[1];
endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: clear sequencing, readback, bypass, r0,
// dropped writes during clear, and reset mid-clear.
module tb_reg_file;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  reg_file_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  reg_file #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic e1, input logic [AW-1:0] a1,
                    input logic e2, input logic [AW-1:0] a2);
    bus.read_en_1 = e1; bus.read_addr_1 = a1;
    bus.read_en_2 = e2; bus.read_addr_2 = a2;
  endtask

  task automatic wr(input logic e, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.write_en = e; bus.write_addr = a; bus.write_data = d;
  endtask

  // Count edges until busy drops, bounded.
  task automatic wait_clear(output int n);
    n = 0;
    while (bus.busy && n < 100) begin
      tick();
      n++;
    end
  endtask

  int n;

  initial begin
    rd(1'b0, '0, 1'b0, '0);
    wr(1'b0, '0, '0);
    rst = 1'b0;

    // Reset state, with reads enabled to prove they are forced to zero.
    rd(1'b1, 5'd5, 1'b1, 5'd9);
    repeat (3) tick();
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_wdrop", 32'(bus.write_dropped), 32'd0);
    chk("rst_rd1", bus.read_data_1, 32'h0);
    chk("rst_rd2", bus.read_data_2, 32'h0);

    // Clear takes exactly 31 cycles after release.
    rst = 1'b1;
    wait_clear(n);
    chk("clear_len", 32'(n), 32'd31);

    // Every register reads zero afterwards on both ports.
    for (int a = 1; a < 32; a++) begin
      rd(1'b1, AW'(a), 1'b1, AW'(a));
      #1;
      chk($sformatf("clr_p1_r%0d", a), bus.read_data_1, 32'h0);
      chk($sformatf("clr_p2_r%0d", a), bus.read_data_2, 32'h0);
    end

    // Write/readback; disabled port 2 reads zero.
    wr(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    wr(1'b0, '0, '0);
    rd(1'b1, 5'd5, 1'b0, 5'd5);
    #1;
    chk("wb_rd1", bus.read_data_1, 32'hDEADBEEF);
    chk("wb_rd2_off", bus.read_data_2, 32'h0);

    // Bypass: r7 written this cycle, r8 from storage.
    wr(1'b1, 5'd8, 32'hA5A5A5A5);
    tick();
    wr(1'b1, 5'd7, 32'h12345678);
    rd(1'b1, 5'd7, 1'b1, 5'd8);
    #1;
    chk("byp_rd1", bus.read_data_1, 32'h12345678);
    chk("byp_rd2", bus.read_data_2, 32'hA5A5A5A5);
    tick();
    wr(1'b0, '0, '0);
    #1;
    chk("byp_commit", bus.read_data_1, 32'h12345678);
    // Same address on both ports while bypassing.
    wr(1'b1, 5'd7, 32'h0BADF00D);
    rd(1'b1, 5'd7, 1'b1, 5'd7);
    #1;
    chk("byp_both1", bus.read_data_1, 32'h0BADF00D);
    chk("byp_both2", bus.read_data_2, 32'h0BADF00D);
    tick();
    wr(1'b0, '0, '0);

    // r0 protection.
    wr(1'b1, 5'd0, 32'hFFFFFFFF);
    rd(1'b1, 5'd0, 1'b1, 5'd0);
    #1;
    chk("r0_rd1", bus.read_data_1, 32'h0);
    chk("r0_rd2", bus.read_data_2, 32'h0);
    tick();
    wr(1'b0, '0, '0);
    #1;
    chk("r0_later", bus.read_data_1, 32'h0);
    chk("r0_wdrop", 32'(bus.write_dropped), 32'd0);

    // Write during clear is dropped and flagged.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (9) tick();
    wr(1'b1, 5'd31, 32'h1);
    rd(1'b1, 5'd5, 1'b1, 5'd31);
    #1;
    chk("clr_busy_rd1", bus.read_data_1, 32'h0);
    chk("clr_busy_rd2", bus.read_data_2, 32'h0);
    tick();
    wr(1'b0, '0, '0);
    chk("drop_flag", 32'(bus.write_dropped), 32'd1);
    wait_clear(n);
    chk("clear_len2", 32'(n), 32'd21);
    #1;
    chk("drop_r31", bus.read_data_2, 32'h0);
    chk("clr_r5", bus.read_data_1, 32'h0);
    chk("drop_sticky", 32'(bus.write_dropped), 32'd1);

    // Reset clears the sticky flag.
    rst = 1'b0;
    tick();
    chk("rst2_wdrop", 32'(bus.write_dropped), 32'd0);
    chk("rst2_busy", 32'(bus.busy), 32'd1);

    // Reset mid-clear restarts the full sequence.
    rst = 1'b1;
    repeat (15) tick();
    chk("mid_busy", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    wait_clear(n);
    chk("mid_len", 32'(n), 32'd31);

    // Write on the first IDLE cycle is accepted.
    wr(1'b1, 5'd3, 32'hCAFEF00D);
    tick();
    wr(1'b0, '0, '0);
    rd(1'b1, 5'd3, 1'b1, 5'd3);
    #1;
    chk("idle0_rd1", bus.read_data_1, 32'hCAFEF00D);
    chk("idle0_rd2", bus.read_data_2, 32'hCAFEF00D);
    chk("idle0_wdrop", 32'(bus.write_dropped), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_file.md
# reg_file

General-purpose register file that answers the decode stage's two register read requests and accepts the write-back stage's single write per cycle. It holds 2^ADDR_WIDTH registers with r0 hardwired to zero, and bypasses a same-cycle write to the read ports. After every reset, a clear sequencer zeroes the array one entry per cycle so the storage can map to RAM without a parallel reset. A `busy` output stalls the pipeline until the clear finishes.

## Interface
- ADDR_WIDTH, 5, register address width; depth = 2^ADDR_WIDTH (32).
- DATA_WIDTH, 32, register data width.

- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-low.
- read_en_1  input  1  read port 1 enable, from decode.
- read_addr_1  input  ADDR_WIDTH  read port 1 address.
- read_data_1  output  DATA_WIDTH  read port 1 data; combinational.
- read_en_2  input  1  read port 2 enable.
- read_addr_2  input  ADDR_WIDTH  read port 2 address.
- read_data_2  output  DATA_WIDTH  read port 2 data; combinational.
- write_en  input  1  write enable, from write-back.
- write_addr  input  ADDR_WIDTH  write address.
- write_data  input  DATA_WIDTH  write data.
- busy  output  1  clear sequence in progress; the pipeline must stall while high.
- write_dropped  output  1  sticky flag: a write was discarded because `busy` was high.

## Operation
- Storage: array `regs[1..2^ADDR_WIDTH-1]`. r0 has no storage and always reads 0.
- Clear sequencer, two states:
  - CLEAR: `clr_idx` starts at 1. Each cycle writes `regs[clr_idx] <= 0` and increments `clr_idx`. On the cycle it writes the last index (31), the next state is IDLE.
  - IDLE: no action. Stays in IDLE until the next reset.
- While rst=0 at a clock edge: state <= CLEAR, `clr_idx` <= 1, `write_dropped` <= 0. No array write happens on a reset edge.
- `busy` = (state == CLEAR). It is a registered state decode, so it is 1 throughout reset and during the first clear cycle.
- Writes:
  - In IDLE, with write_en=1 and write_addr≠0: `regs[write_addr] <= write_data` at the edge.
  - Writes to r0 are ignored silently. They do not set `write_dropped`.
  - In CLEAR, with write_en=1 and write_addr≠0: the write is discarded and `write_dropped` <= 1. The clear write for that cycle still happens.
- Read data, port n, by priority:
  1. 0 if read_en_n=0, read_addr_n=0, or busy=1;
  2. else write_data if write_en=1 and write_addr=read_addr_n (bypass);
  3. else regs[read_addr_n].
- Both ports are independent. Both may read the same address, including the bypassed one.

## Timing
- Read latency: 0 cycles (combinational from addr/enable/write inputs).
- Write latency: a write is committed at the edge it is presented. It is visible in the same cycle via bypass and from storage on every later cycle.
- Clear duration: after rst rises, `busy` stays high for exactly 2^ADDR_WIDTH−1 = 31 cycles, then drops.
- Reset values: busy=1, write_dropped=0, read_data_1=read_data_2=0.
- Reset mid-clear: the sequence restarts at index 1 and again takes the full 31 cycles after rst rises.
- Simultaneous write and read of the same address with both enabled: the read returns write_data.
- Write of r0 in the same cycle as a read of r0: the read returns 0.
- Writes in the same cycle `busy` falls (first IDLE cycle) are accepted.

## Test plan
- Reset and clear: hold rst=0 for 3 cycles, then release. Expect busy=1 for exactly 31 cycles after release. Then reading every address 1..31 on both ports returns 0x00000000.
- Write/readback: write 0xDEADBEEF to r5. On the next cycle, read_addr_1=5 gives 0xDEADBEEF, and read_addr_2=5 with read_en_2=0 gives 0.
- Bypass: in one cycle, write r7=0x12345678 while port 1 reads r7 and port 2 reads r8 (holding 0xA5A5A5A5). Expect 0x12345678 and 0xA5A5A5A5 in the same cycle.
- r0 protection: write r0=0xFFFFFFFF while both ports read r0. Expect 0 on both ports, 0 on a later read of r0, and write_dropped=0.
- Write during clear: at cycle 10 of the clear, write r31=0x1. Expect write_dropped=1, and r31 reads 0 after busy falls. Then reset again and expect write_dropped=0.
- Reset mid-clear: after 15 clear cycles, hold rst=0 for 1 cycle. After release, busy stays high for another full 31 cycles.
